cp_timing_sync: RTL

CP_TIMING_SYNC -- requirements
Module: cp_timing_sync

---
 rtl/cp_sync_pkg.sv | 19 +
 rtl/cp_cmul.sv | 33 +++
 rtl/cp_timing_sync.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/cp_sync_pkg.sv
// cp_sync_pkg: shared widths, default geometry and FSM state type for the
// cyclic-prefix timing synchroniser.
package cp_sync_pkg;

    localparam int ADDR_W         = 12;
    localparam int SMP_W          = 9;
    localparam int PROD_W         = 2 * SMP_W + 1;
    localparam int DEF_NFFT       = 64;
    localparam int DEF_NCP        = 16;
    localparam int DEF_SEARCH_LEN = 80;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SEARCH,
        DONE
    } state_t;

endpackage

// File: rtl/cp_cmul.sv
// cp_cmul: registered conjugate multiply p = a * conj(b), one-cycle latency.
module cp_cmul
    import cp_sync_pkg::*;
(
    input  logic                     clk,
    input  logic signed [SMP_W-1:0]  a_re,
    input  logic signed [SMP_W-1:0]  a_im,
    input  logic signed [SMP_W-1:0]  b_re,
    input  logic signed [SMP_W-1:0]  b_im,
    output logic signed [PROD_W-1:0] p_re_p1,
    output logic signed [PROD_W-1:0] p_im_p1
);

    logic signed [PROD_W-1:0] ar_p0, ai_p0, br_p0, bi_p0;
    logic signed [PROD_W-1:0] re_p0, im_p0;

    // Widen operands first so the full 9x9 product and the pair sum are kept.
    always_comb begin
        ar_p0 = PROD_W'(a_re);
        ai_p0 = PROD_W'(a_im);
        br_p0 = PROD_W'(b_re);
        bi_p0 = PROD_W'(b_im);
        re_p0 = ar_p0 * br_p0 + ai_p0 * bi_p0;
        im_p0 = ai_p0 * br_p0 - ar_p0 * bi_p0;
    end

    // ---- p0 -> p1: product register ----
    always_ff @(posedge clk) begin
        p_re_p1 <= re_p0;
        p_im_p1 <= im_p0;
    end

endmodule

// File: rtl/cp_timing_sync.sv
// cp_timing_sync: searches SEARCH_LEN candidate symbol starts for the peak of
// |sum x[d+n]*conj(x[d+n+NFFT])| over an NCP-sample window.
// Optional feature: define CP_SYNC_DETECT_EN to add det_thresh / detected.
module cp_timing_sync
    import cp_sync_pkg::*;
#(
    parameter  int NFFT       = DEF_NFFT,
    parameter  int NCP        = DEF_NCP,
    parameter  int SEARCH_LEN = DEF_SEARCH_LEN,
    localparam int ACC_W      = PROD_W + $clog2(NCP)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    output logic                    mem_mode,
    output logic [ADDR_W-1:0]       mem_addr,
    output logic [ADDR_W-1:0]       mem_offset,
    input  logic signed [SMP_W-1:0] mem_re1,
    input  logic signed [SMP_W-1:0] mem_im1,
    input  logic signed [SMP_W-1:0] mem_re2,
    input  logic signed [SMP_W-1:0] mem_im2,
    output logic                    busy,
    output logic                    done,
    output logic [ADDR_W-1:0]       est_addr,
    output logic [ACC_W:0]          peak_metric
`ifdef CP_SYNC_DETECT_EN
    ,
    input  logic [ACC_W:0]          det_thresh,
    output logic                    detected
`endif
);

    // cnt = cycles since start was accepted. Sample k returns at cnt=k+1, its
    // product is registered at cnt=k+2 and enters the sums at that edge.
    localparam int CNT_W      = $clog2(SEARCH_LEN + NCP + 3) + 1;
    localparam int FILL_END   = NCP + 1;
    localparam int SUM_FIRST  = 2;
    localparam int SUM_LAST   = SEARCH_LEN + NCP;
    localparam int LAST_ISSUE = SEARCH_LEN + NCP - 2;
    localparam int LAST_CMP   = SEARCH_LEN + NCP + 1;
    localparam int DONE_AT    = SEARCH_LEN + NCP + 2;

    state_t                   state, state_nxt;
    logic [CNT_W-1:0]         cnt;
    logic                     accept, sum_en, cmp_en;
    logic signed [PROD_W-1:0] prod_re_p1, prod_im_p1;
    logic signed [PROD_W-1:0] dl_re_p2 [NCP];
    logic signed [PROD_W-1:0] dl_im_p2 [NCP];
    logic signed [ACC_W-1:0]  sum_re_p2, sum_im_p2;
    logic [ACC_W:0]           metric_p2, peak_q;
    logic [ADDR_W-1:0]        cand_addr, peak_addr;

    function automatic logic signed [ACC_W-1:0] sext(input logic signed [PROD_W-1:0] v);
        return ACC_W'(v);
    endfunction

    function automatic logic [ACC_W:0] mag(input logic signed [ACC_W-1:0] v);
        logic signed [ACC_W:0] w;
        w = {v[ACC_W-1], v};
        if (w < 0) w = -w;
        return w;
    endfunction

    cp_cmul u_cmul (
        .clk     (clk),
        .a_re    (mem_re1),
        .a_im    (mem_im1),
        .b_re    (mem_re2),
        .b_im    (mem_im2),
        .p_re_p1 (prod_re_p1),
        .p_im_p1 (prod_im_p1)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; start is only looked at in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = FILL;
            FILL:    if (cnt == CNT_W'(FILL_END)) state_nxt = SEARCH;
            SEARCH:  if (cnt == CNT_W'(DONE_AT)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs and enables decoded from state and cycle count.
    always_comb begin
        busy       = (state == FILL) || (state == SEARCH);
        done       = (state == DONE);
        mem_mode   = 1'b1;
        mem_offset = ADDR_W'(NFFT);
        accept     = (state == IDLE) && start;
        sum_en     = busy && (cnt >= CNT_W'(SUM_FIRST)) && (cnt <= CNT_W'(SUM_LAST));
        cmp_en     = (state == SEARCH) && (cnt <= CNT_W'(LAST_CMP));
        metric_p2  = mag(sum_re_p2) + mag(sum_im_p2);
    end

    // Cycle counter and read-address generator (address wraps at 4096).
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            mem_addr <= '0;
        end else if (accept) begin
            cnt      <= '0;
            mem_addr <= base_addr;
        end else if (busy) begin
            cnt <= cnt + 1'b1;
            if (cnt < CNT_W'(LAST_ISSUE)) mem_addr <= mem_addr + 1'b1;
        end
    end

    // ---- p1 -> p2: delay line and running window sums ----
    always_ff @(posedge clk) begin
        if (rst || accept) begin
            for (int i = 0; i < NCP; i++) begin
                dl_re_p2[i] <= '0;
                dl_im_p2[i] <= '0;
            end
            sum_re_p2 <= '0;
            sum_im_p2 <= '0;
        end else if (sum_en) begin
            dl_re_p2[0] <= prod_re_p1;
            dl_im_p2[0] <= prod_im_p1;
            for (int i = 1; i < NCP; i++) begin
                dl_re_p2[i] <= dl_re_p2[i-1];
                dl_im_p2[i] <= dl_im_p2[i-1];
            end
            sum_re_p2 <= sum_re_p2 + sext(prod_re_p1) - sext(dl_re_p2[NCP-1]);
            sum_im_p2 <= sum_im_p2 + sext(prod_im_p1) - sext(dl_im_p2[NCP-1]);
        end
    end

    // Running peak; strict compare so ties keep the earliest candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            peak_q    <= '0;
            peak_addr <= '0;
            cand_addr <= '0;
        end else if (accept) begin
            peak_q    <= '0;
            peak_addr <= base_addr;
            cand_addr <= base_addr;
        end else if (cmp_en) begin
            if (metric_p2 > peak_q) begin
                peak_q    <= metric_p2;
                peak_addr <= cand_addr;
            end
            cand_addr <= cand_addr + 1'b1;
        end
    end

    // Publish results on entry to DONE and hold them until the next search ends.
    always_ff @(posedge clk) begin
        if (rst) begin
            est_addr    <= '0;
            peak_metric <= '0;
`ifdef CP_SYNC_DETECT_EN
            detected    <= 1'b0;
`endif
        end else if ((state == SEARCH) && (cnt == CNT_W'(DONE_AT))) begin
            est_addr    <= peak_addr;
            peak_metric <= peak_q;
`ifdef CP_SYNC_DETECT_EN
            detected    <= (peak_q > det_thresh);
`endif
        end
    end

endmodule
